// File: rtl/multi_edge_sync_if.sv
// Bundle of the multi_edge_sync channel inputs and status outputs.
// The board/driver side uses master; the synchroniser uses slave.
interface multi_edge_sync_if #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 8
);

  logic [CHANNELS-1:0]           async_in;
  logic [2*CHANNELS-1:0]         edge_mode;
  logic [CHANNELS-1:0]           count_clr;
  logic [CHANNELS-1:0]           sync_out;
  logic [CHANNELS-1:0]           edge_pulse;
  logic                          any_edge;
  logic [CHANNELS*CNT_WIDTH-1:0] edge_count;
  logic [CHANNELS-1:0]           overflow;

  modport master (
    output async_in, edge_mode, count_clr,
    input  sync_out, edge_pulse, any_edge, edge_count, overflow
  );

  modport slave (
    input  async_in, edge_mode, count_clr,
    output sync_out, edge_pulse, any_edge, edge_count, overflow
  );

endinterface

// File: rtl/multi_edge_sync.sv
// Multi-channel async input front end: synchroniser chain, glitch filter,
// mode-selected edge pulses and a saturating per-channel event counter.
module multi_edge_sync #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 3,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic             clk50,
  input  logic             reset,
  multi_edge_sync_if.slave bus
);

  localparam int unsigned         FC_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [FC_W-1:0]     FC_LAST = FC_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [CHANNELS-1:0]    s_w;

  logic [FC_W-1:0]        fc_q [CHANNELS];
  logic [FC_W-1:0]        fc_d [CHANNELS];
  logic [CHANNELS-1:0]    f_q;
  logic [CHANNELS-1:0]    f_d;
  logic [CHANNELS-1:0]    pulse_q;
  logic [CHANNELS-1:0]    pulse_d;

  logic [CNT_WIDTH-1:0]   cnt_q [CHANNELS];
  logic [CNT_WIDTH-1:0]   cnt_d [CHANNELS];
  logic [CHANNELS-1:0]    ovf_q;
  logic [CHANNELS-1:0]    ovf_d;

  logic [CHANNELS*CNT_WIDTH-1:0] cnt_flat;

  // Plain flop chain per channel, nothing between stages
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.async_in[i]};
      end
    end
  end

  always_comb begin
    s_w = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      s_w[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Stability filter; the pulse is produced on the edge that updates f
  always_comb begin
    fc_d    = fc_q;
    f_d     = f_q;
    pulse_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s_w[i] == f_q[i]) begin
        fc_d[i] = '0;
      end else if (fc_q[i] == FC_LAST) begin
        f_d[i]     = s_w[i];
        fc_d[i]    = '0;
        pulse_d[i] = s_w[i] ? bus.edge_mode[2*i] : bus.edge_mode[2*i+1];
      end else begin
        fc_d[i] = fc_q[i] + FC_W'(1);
      end
    end
  end

  // Counter consumes the registered pulse; clear wins but keeps a coincident edge
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.count_clr[i]) begin
        cnt_d[i] = pulse_q[i] ? CNT_WIDTH'(1) : '0;
        ovf_d[i] = 1'b0;
      end else if (pulse_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        fc_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      f_q     <= '0;
      pulse_q <= '0;
      ovf_q   <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        fc_q[i]  <= fc_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      f_q     <= f_d;
      pulse_q <= pulse_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_flat[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end

  assign bus.sync_out   = f_q;
  assign bus.edge_pulse = pulse_q;
  assign bus.any_edge   = |pulse_q;
  assign bus.edge_count = cnt_flat;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_multi_edge_sync.sv
// Directed bench for multi_edge_sync: a default instance plus a 2-bit-counter
// instance for saturation, checked with immediate assertions.
module tb_multi_edge_sync;

  logic clk50;
  logic reset;

  multi_edge_sync_if #(.CHANNELS(4), .CNT_WIDTH(8)) ia ();
  multi_edge_sync_if #(.CHANNELS(4), .CNT_WIDTH(2)) ib ();

  multi_edge_sync #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .CNT_WIDTH(8)) dut_a (
    .clk50 (clk50),
    .reset (reset),
    .bus   (ia)
  );

  multi_edge_sync #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .CNT_WIDTH(2)) dut_b (
    .clk50 (clk50),
    .reset (reset),
    .bus   (ib)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  int n_cmp = 0;
  int n_err = 0;

  // Pulse bookkeeping sampled mid-cycle
  int pulses_a [4];
  int any_a   = 0;
  int any_bad = 0;

  always @(negedge clk50) begin
    if (!reset) begin
      for (int c = 0; c < 4; c++) begin
        if (ia.edge_pulse[c]) pulses_a[c]++;
      end
      if (ia.any_edge) any_a++;
      if ((ia.any_edge !== |ia.edge_pulse) || (ib.any_edge !== |ib.edge_pulse)) any_bad++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int        mode_exp [4] = '{0, 2, 2, 4};
    int        sat_cnt  [5] = '{1, 2, 3, 3, 3};
    int        sat_ovf  [5] = '{0, 0, 0, 1, 1};
    logic [1:0] md      [4] = '{2'b11, 2'b01, 2'b10, 2'b11};
    int        hold     [4];
    int        exp_cnt  [4];
    int        p0       [4];
    logic [3:0] lvl;
    int        p;
    int        a;

    reset        = 1'b1;
    ia.async_in  = '0;
    ia.edge_mode = '0;
    ia.count_clr = '0;
    ib.async_in  = '0;
    ib.edge_mode = '0;
    ib.count_clr = '0;

    // Reset state
    tick(3);
    chk("rst_sync_out", 32'(ia.sync_out), 0);
    chk("rst_pulse", 32'(ia.edge_pulse), 0);
    chk("rst_any", 32'(ia.any_edge), 0);
    chk("rst_count", 32'(ia.edge_count), 0);
    chk("rst_ovf", 32'(ia.overflow), 0);
    chk("rst_count_b", 32'(ib.edge_count), 0);
    reset = 1'b0;
    tick(2);
    chk("post_rst_sync_out", 32'(ia.sync_out), 0);

    // ch0 rising only, ch1 both
    ia.edge_mode = 8'b00_00_11_01;
    ia.async_in[0] = 1'b1;
    tick(4);
    chk("ch0_early_sync", 32'(ia.sync_out[0]), 0);
    chk("ch0_early_pulse", 32'(ia.edge_pulse), 0);
    tick(1);
    chk("ch0_rise_sync", 32'(ia.sync_out[0]), 1);
    chk("ch0_rise_pulse", 32'(ia.edge_pulse), 4'b0001);
    chk("ch0_rise_any", 32'(ia.any_edge), 1);
    chk("ch0_cnt_before", 32'(ia.edge_count[7:0]), 0);
    tick(1);
    chk("ch0_pulse_width", 32'(ia.edge_pulse), 0);
    chk("ch0_cnt_after", 32'(ia.edge_count[7:0]), 1);
    ia.async_in[0] = 1'b0;
    tick(5);
    chk("ch0_fall_sync", 32'(ia.sync_out[0]), 0);
    chk("ch0_fall_nopulse", 32'(ia.edge_pulse), 0);
    tick(2);
    chk("ch0_cnt_final", 32'(ia.edge_count[7:0]), 1);
    chk("ch0_pulses", 32'(pulses_a[0]), 1);

    // Glitch rejection on ch1
    ia.async_in[1] = 1'b1;
    tick(2);
    ia.async_in[1] = 1'b0;
    tick(8);
    chk("glitch2_sync", 32'(ia.sync_out[1]), 0);
    chk("glitch2_cnt", 32'(ia.edge_count[15:8]), 0);
    chk("glitch2_pulses", 32'(pulses_a[1]), 0);
    ia.async_in[1] = 1'b1;
    tick(3);
    ia.async_in[1] = 1'b0;
    tick(12);
    chk("pulse3_sync", 32'(ia.sync_out[1]), 0);
    chk("pulse3_cnt", 32'(ia.edge_count[15:8]), 2);
    chk("pulse3_pulses", 32'(pulses_a[1]), 2);

    // Modes on ch2
    for (int m = 0; m < 4; m++) begin
      ia.edge_mode[5:4] = 2'(m);
      ia.count_clr[2] = 1'b1;
      tick(1);
      ia.count_clr[2] = 1'b0;
      p = pulses_a[2];
      a = any_a;
      repeat (4) begin
        ia.async_in[2] = ~ia.async_in[2];
        tick(8);
      end
      chk($sformatf("mode%0d_cnt", m), 32'(ia.edge_count[23:16]), 32'(mode_exp[m]));
      chk($sformatf("mode%0d_pulses", m), 32'(pulses_a[2] - p), 32'(mode_exp[m]));
      chk($sformatf("mode%0d_any", m), 32'(any_a - a), 32'(mode_exp[m]));
    end

    // Saturation with a 2-bit counter
    ib.edge_mode = 8'b00_00_00_11;
    for (int e = 0; e < 5; e++) begin
      ib.async_in[0] = ~ib.async_in[0];
      tick(8);
      chk($sformatf("sat_cnt_e%0d", e + 1), 32'(ib.edge_count[1:0]), 32'(sat_cnt[e]));
      chk($sformatf("sat_ovf_e%0d", e + 1), 32'(ib.overflow[0]), 32'(sat_ovf[e]));
    end
    ib.count_clr[0] = 1'b1;
    tick(1);
    ib.count_clr[0] = 1'b0;
    chk("clr_cnt", 32'(ib.edge_count[1:0]), 0);
    chk("clr_ovf", 32'(ib.overflow[0]), 0);
    ib.async_in[0] = ~ib.async_in[0];
    tick(5);
    chk("clr_edge_pulse", 32'(ib.edge_pulse[0]), 1);
    ib.count_clr[0] = 1'b1;
    tick(1);
    ib.count_clr[0] = 1'b0;
    chk("clr_coinc_cnt", 32'(ib.edge_count[1:0]), 1);
    chk("clr_coinc_ovf", 32'(ib.overflow[0]), 0);
    tick(4);

    // Input held high through reset release
    ia.edge_mode[7:6] = 2'b01;
    reset = 1'b1;
    ia.async_in[3] = 1'b1;
    tick(2);
    chk("rst2_count_a", 32'(ia.edge_count), 0);
    chk("rst2_count_b", 32'(ib.edge_count), 0);
    reset = 1'b0;
    tick(4);
    chk("hold_early_pulse", 32'(ia.edge_pulse), 0);
    tick(1);
    chk("hold_rise_pulse", 32'(ia.edge_pulse), 4'b1000);
    chk("hold_rise_sync", 32'(ia.sync_out), 4'b1000);
    tick(1);
    chk("hold_cnt", 32'(ia.edge_count[31:24]), 1);

    // Reset during a pending filter count
    ia.edge_mode[7:6] = 2'b11;
    ia.async_in[3] = 1'b0;
    tick(3);
    reset = 1'b1;
    #1;
    chk("midrst_sync", 32'(ia.sync_out), 0);
    chk("midrst_pulse", 32'(ia.edge_pulse), 0);
    chk("midrst_count", 32'(ia.edge_count), 0);
    tick(1);
    reset = 1'b0;
    tick(8);
    chk("midrst_pulses", 32'(pulses_a[3]), 1);
    chk("midrst_sync_after", 32'(ia.sync_out), 0);

    // Independent random-but-filter-legal traffic on all channels
    ia.edge_mode = {md[3], md[2], md[1], md[0]};
    ia.count_clr = 4'hF;
    tick(1);
    ia.count_clr = 4'h0;
    lvl = 4'h0;
    for (int c = 0; c < 4; c++) begin
      hold[c]    = 2 * c;
      exp_cnt[c] = 0;
      p0[c]      = pulses_a[c];
    end
    for (int t = 0; t < 200; t++) begin
      for (int c = 0; c < 4; c++) begin
        if (hold[c] > 0) begin
          hold[c]--;
        end else if ($urandom_range(0, 1) == 1) begin
          lvl[c]  = ~lvl[c];
          hold[c] = 2 + int'($urandom_range(0, 4));
          if (lvl[c] && md[c][0]) exp_cnt[c]++;
          if (!lvl[c] && md[c][1]) exp_cnt[c]++;
        end
      end
      ia.async_in = lvl;
      tick(1);
    end
    tick(10);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rand_cnt_ch%0d", c), 32'(ia.edge_count[c*8 +: 8]), 32'(exp_cnt[c]));
      chk($sformatf("rand_pulses_ch%0d", c), 32'(pulses_a[c] - p0[c]), 32'(exp_cnt[c]));
    end
    chk("rand_sync_out", 32'(ia.sync_out), 32'(lvl));
    chk("any_edge_mirror", 32'(any_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
